// File: rtl/enemy_step_sequencer_pkg.sv
// ============================================================================
// enemy_step_sequencer_pkg : shared game types, state encoding and widths
// Rev 1.0
// ============================================================================
`default_nettype none

package enemy_step_sequencer_pkg;

  localparam int IDX_W   = 3;  // enough for up to 8 enemy engines
  localparam int X_W     = 9;
  localparam int Y_W     = 8;
  localparam int C_W     = 6;
  localparam int TIMER_W = 9;
  localparam int DIV_W   = 4;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

  typedef enum logic [2:0] {
    BOOT       = 3'd0,
    INIT       = 3'd1,
    IDLE       = 3'd2,
    GEN        = 3'd3,
    MOVE       = 3'd4,
    DRAW_LINK  = 3'd5,
    GAP        = 3'd6,
    DRAW_ENEMY = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    NO_ACTION = 3'd0,
    ATTACK    = 3'd1,
    UP        = 3'd2,
    DOWN      = 3'd3,
    LEFT      = 3'd4,
    RIGHT     = 3'd5
  } action_t;

  function automatic logic [7:0] idx_onehot(input logic [IDX_W-1:0] idx);
    return 8'(1) << idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/enemy_step_sequencer_if.sv
// ============================================================================
// enemy_step_sequencer_if : frame control, engine handshakes and pixel buses
// Rev 1.0
// ============================================================================
`default_nettype none

interface enemy_step_sequencer_if
  import enemy_step_sequencer_pkg::*;
#(
  parameter int NUM_ENEMIES = 4
);

  logic                         start;
  logic                         frame_tick;
  logic [NUM_ENEMIES-1:0]       enemy_alive;
  logic                         link_draw_done;
  logic [NUM_ENEMIES-1:0]       enemy_draw_done;
  logic [X_W-1:0]               link_x_draw;
  logic [Y_W-1:0]               link_y_draw;
  logic [C_W-1:0]               link_colour;
  logic                         link_write;
  logic [X_W*NUM_ENEMIES-1:0]   enemy_x_bus;
  logic [Y_W*NUM_ENEMIES-1:0]   enemy_y_bus;
  logic [C_W*NUM_ENEMIES-1:0]   enemy_colour_bus;
  logic [NUM_ENEMIES-1:0]       enemy_write_bus;

  logic                         init;
  logic                         idle;
  logic                         gen_move;
  logic                         move_enemies;
  logic                         draw_link;
  logic [NUM_ENEMIES-1:0]       draw_enemies;
  logic [X_W-1:0]               vga_x;
  logic [Y_W-1:0]               vga_y;
  logic [C_W-1:0]               vga_colour;
  logic                         vga_write;
  logic                         overrun;
  logic                         timeout_err;

  // Sequencer side
  modport master (
    input  start, frame_tick, enemy_alive, link_draw_done, enemy_draw_done,
           link_x_draw, link_y_draw, link_colour, link_write,
           enemy_x_bus, enemy_y_bus, enemy_colour_bus, enemy_write_bus,
    output init, idle, gen_move, move_enemies, draw_link, draw_enemies,
           vga_x, vga_y, vga_colour, vga_write, overrun, timeout_err
  );

  // Frame timer, engines and VGA adapter side
  modport slave (
    output start, frame_tick, enemy_alive, link_draw_done, enemy_draw_done,
           link_x_draw, link_y_draw, link_colour, link_write,
           enemy_x_bus, enemy_y_bus, enemy_colour_bus, enemy_write_bus,
    input  init, idle, gen_move, move_enemies, draw_link, draw_enemies,
           vga_x, vga_y, vga_colour, vga_write, overrun, timeout_err
  );

endinterface

`default_nettype wire

// File: rtl/enemy_step_sequencer_next_live_index.sv
// ============================================================================
// next_live_index : lowest live enemy index above the last one served
// Rev 1.0
// ============================================================================
`default_nettype none

module next_live_index
  import enemy_step_sequencer_pkg::*;
#(
  parameter int NUM_ENEMIES = 4
) (
  input  logic [NUM_ENEMIES-1:0] i_alive,
  input  logic [IDX_W-1:0]       i_last,
  input  logic                   i_from_start,
  output logic [IDX_W-1:0]       o_index,
  output logic                   o_found
);

  // i_from_start means nothing has been served yet this frame, so index 0 qualifies
  always_comb begin
    o_index = '0;
    o_found = 1'b0;
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      if (!o_found && i_alive[i] && (i_from_start || (IDX_W'(i) > i_last))) begin
        o_index = IDX_W'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/enemy_step_sequencer.sv
// ============================================================================
// enemy_step_sequencer : per-frame strobe sequencer and VGA write-port arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module enemy_step_sequencer
  import enemy_step_sequencer_pkg::*;
#(
  parameter int NUM_ENEMIES  = 4,
  parameter int MOVE_DIV     = 4,
  parameter int DRAW_TIMEOUT = 300
) (
  input  logic                   clock,
  input  logic                   reset,
  enemy_step_sequencer_if.master bus
);

  state_t               r_state,       w_state_next;
  logic [DIV_W-1:0]     r_div,         w_div_next;
  logic [TIMER_W-1:0]   r_timer,       w_timer_next;
  logic [IDX_W-1:0]     r_idx,         w_idx_next;
  logic                 r_after_link,  w_after_link_next;
  logic                 r_overrun,     w_overrun_next;
  logic                 r_timeout_err, w_timeout_err_next;

  logic [IDX_W-1:0]       w_found_idx;
  logic                   w_found;
  logic [7:0]             w_grant_oh8;
  logic [NUM_ENEMIES-1:0] w_grant_oh;
  logic                   w_sel_done;
  logic                   w_timer_expired;
  logic                   w_tick_dropped;

  next_live_index #(
    .NUM_ENEMIES (NUM_ENEMIES)
  ) u_next_live_index (
    .i_alive      (bus.enemy_alive),
    .i_last       (r_idx),
    .i_from_start (r_after_link),
    .o_index      (w_found_idx),
    .o_found      (w_found)
  );

  assign w_grant_oh8     = idx_onehot(r_idx);
  assign w_grant_oh      = w_grant_oh8[NUM_ENEMIES-1:0];
  assign w_sel_done      = |(bus.enemy_draw_done & w_grant_oh);
  assign w_timer_expired = (r_timer == TIMER_W'(DRAW_TIMEOUT - 1));

  // A tick coinciding with start in BOOT is swallowed by the start, not flagged
  assign w_tick_dropped  = bus.frame_tick && (r_state != IDLE) &&
                           !((r_state == BOOT) && bus.start);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= BOOT;
      r_div         <= '0;
      r_timer       <= '0;
      r_idx         <= '0;
      r_after_link  <= 1'b0;
      r_overrun     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_div         <= w_div_next;
      r_timer       <= w_timer_next;
      r_idx         <= w_idx_next;
      r_after_link  <= w_after_link_next;
      r_overrun     <= w_overrun_next;
      r_timeout_err <= w_timeout_err_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_div_next         = r_div;
    w_timer_next       = '0;
    w_idx_next         = r_idx;
    w_after_link_next  = r_after_link;
    w_overrun_next     = r_overrun | w_tick_dropped;
    w_timeout_err_next = r_timeout_err;

    case (r_state)
      BOOT: begin
        if (bus.start) w_state_next = INIT;
      end
      INIT: begin
        // Preload so the first frame after init moves the enemies
        w_div_next   = DIV_W'(MOVE_DIV - 1);
        w_state_next = IDLE;
      end
      IDLE: begin
        if (bus.frame_tick) begin
          if (r_div == DIV_W'(MOVE_DIV - 1)) begin
            w_div_next   = '0;
            w_state_next = GEN;
          end else begin
            w_div_next   = r_div + DIV_W'(1);
            w_state_next = DRAW_LINK;
          end
        end
      end
      GEN:  w_state_next = MOVE;
      MOVE: w_state_next = DRAW_LINK;
      DRAW_LINK: begin
        if (bus.link_draw_done || w_timer_expired) begin
          w_timeout_err_next = r_timeout_err | !bus.link_draw_done;
          w_after_link_next  = 1'b1;
          w_state_next       = GAP;
        end else begin
          w_timer_next = r_timer + TIMER_W'(1);
        end
      end
      GAP: begin
        if (w_found) begin
          w_idx_next   = w_found_idx;
          w_state_next = DRAW_ENEMY;
        end else begin
          w_state_next = IDLE;
        end
      end
      DRAW_ENEMY: begin
        if (w_sel_done || w_timer_expired) begin
          w_timeout_err_next = r_timeout_err | !w_sel_done;
          w_after_link_next  = 1'b0;
          w_state_next       = GAP;
        end else begin
          w_timer_next = r_timer + TIMER_W'(1);
        end
      end
      default: w_state_next = BOOT;
    endcase
  end

  // Moore decode of strobes, grants and the pixel-port mux
  always_comb begin
    bus.init         = OFF;
    bus.idle         = OFF;
    bus.gen_move     = OFF;
    bus.move_enemies = OFF;
    bus.draw_link    = OFF;
    bus.draw_enemies = '0;
    bus.vga_x        = '0;
    bus.vga_y        = '0;
    bus.vga_colour   = '0;
    bus.vga_write    = OFF;

    case (r_state)
      INIT: bus.init         = ON;
      IDLE: bus.idle         = ON;
      GEN:  bus.gen_move     = ON;
      MOVE: bus.move_enemies = ON;
      DRAW_LINK: begin
        bus.draw_link  = ON;
        bus.vga_x      = bus.link_x_draw;
        bus.vga_y      = bus.link_y_draw;
        bus.vga_colour = bus.link_colour;
        bus.vga_write  = bus.link_write;
      end
      DRAW_ENEMY: begin
        bus.draw_enemies = w_grant_oh;
        for (int i = 0; i < NUM_ENEMIES; i++) begin
          if (r_idx == IDX_W'(i)) begin
            bus.vga_x      = bus.enemy_x_bus[i*X_W +: X_W];
            bus.vga_y      = bus.enemy_y_bus[i*Y_W +: Y_W];
            bus.vga_colour = bus.enemy_colour_bus[i*C_W +: C_W];
            bus.vga_write  = bus.enemy_write_bus[i];
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.overrun     = r_overrun;
  assign bus.timeout_err = r_timeout_err;

endmodule

`default_nettype wire
